hlsm_rf_loader: RTL and testbench
=================================

# hlsm_rf_loader

Write-side companion to the max/min difference datapath: accepts a stream of 256 bytes over a valid/ready handshake and writes them, in address order 0..255, into the write port of the 256x8 register file (`Register256_8`). The max/min datapath then reads the same file through its read port. `done` tells the top-level sequencer that the file is fully loaded, so it can pulse `go` to the max/min controller.

## Interface
- `DATA_W`, default 8: byte width; must match the register file data width.
- `ADDR_W`, default 8: address width; depth is 2^`ADDR_W` (256).

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: reset, synchronous and active-high.
- `go`  in  1: starts a load pass; sampled only in IDLE.
- `in_valid`  in  1: `in_data` is valid.
- `in_data`  in  `DATA_W`: input byte.
- `in_ready`  out  1: loader can accept a byte this cycle.
- `W_en`  out  1: register file write enable.
- `W_Addr`  out  `ADDR_W`: register file write address.
- `W_Data`  out  `DATA_W`: register file write data.
- `busy`  out  1: high in LOAD and FLUSH.
- `done`  out  1: one-cycle pulse when all 256 writes are committed.
- `count`  out  `ADDR_W`+1: bytes accepted in the current pass (0..256).
- `checksum`  out  `DATA_W`: running sum of accepted bytes; see Configuration.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE
  - `in_ready`=0 and `busy`=0.
  - `go`=1 moves to LOAD and clears `count` and the address counter (and `checksum` when enabled).
- LOAD
  - `in_ready`=1.
  - An accept occurs on `in_valid` & `in_ready`.
  - Each accept registers `W_en`=1, `W_Addr`=current address and `W_Data`=`in_data` for the next cycle. It also increments the address and `count`.
  - The accept at address 255 moves the FSM to FLUSH.
- FLUSH
  - `in_ready`=0; the final write (address 255) is on the port this cycle.
  - Unconditional move to DONE.
- DONE
  - `done`=1 for exactly one cycle; `count` holds 256.
  - Unconditional move to IDLE.
- `W_en` is high only in the cycle after an accept. `W_Addr`/`W_Data` hold their last values when `W_en`=0.
- Address arithmetic: `ADDR_W`-bit counter wraps 255 -> 0, but the FSM leaves LOAD on that wrap, so address 0 is never rewritten within a pass. `count` is `ADDR_W`+1 bits wide so that it can reach 256.
- `go` is ignored outside IDLE, including a `go` in the same cycle as `done`.
- `in_valid` gaps in LOAD stall the pass indefinitely, with no timeout. `in_data` is not consumed while `in_ready`=0.
- The loader never clears the register file. A reset mid-pass leaves already-written entries in the file.

## Timing
- Reset values: `in_ready`=0, `W_en`=0, `W_Addr`=0, `W_Data`=0, `busy`=0, `done`=0, `count`=0, `checksum`=0; FSM in IDLE.
- Reset wins over every other input in the same cycle.
- `go` at edge t: LOAD from cycle t+1, so `in_ready`=1 at t+1.
- Accept at edge t: `W_en`=1 during cycle t+1; the register file captures the data at edge t+1. Write latency is 1 cycle.
- With `in_valid` held high, 256 accepts take 256 consecutive cycles.
- The last accept at edge t gives FLUSH at t+1 and `done` at t+2. The earliest next `go` is sampled in IDLE at t+3.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LOADER_CHECKSUM_EN`
  - Defined: `checksum` is a mod-2^`DATA_W` running sum of accepted bytes. It updates at each accept, is cleared on the IDLE->LOAD transition, and holds its value through DONE and IDLE until the next `go`.
  - Undefined: no adder or register is built, and `checksum` is tied to 0.

## Test plan
- Reset, then `go` with `in_valid` held high and `in_data`=address:
  - 256 writes with `W_Addr`=`W_Data`=0..255 in consecutive cycles.
  - `done` pulses 2 cycles after the last accept; `count`=256.
- `in_valid` toggled 1/0 every cycle:
  - Writes occur only in the cycles after accepts, with no address skipped or repeated.
  - `done` arrives after 511 LOAD cycles.
- `go` pulsed during LOAD and again in the `done` cycle:
  - Both are ignored; a single pass completes.
  - A new `go` in IDLE starts a fresh pass from address 0.
- Rst asserted after 100 accepts:
  - All outputs return to reset values next cycle; no further `W_en`.
  - A subsequent `go` restarts at address 0.
- With `LOADER_CHECKSUM_EN` defined and every byte 0x01: `checksum`=0x00 after 256 accepts (wrap), and 0x80 after 128.
- Without the macro: `checksum` stays 0 through a full pass.

Source files
------------

// File: rtl/hlsm_rf_loader.sv
`default_nettype none
// ============================================================================
// Module   : hlsm_rf_loader
// Purpose  : Streams 2^ADDR_W bytes over valid/ready into a register file write
//            port in address order, then pulses done. Optional running checksum
//            is built only when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hlsm_rf_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              go,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              W_en,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                w_en_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic                in_ready_q, busy_q, done_q;
    logic                accept;
    logic                start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        accept  = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    start   = 1'b1;
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                accept = in_valid;
                if (in_valid) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_q + CNT_ONE;
                    // The wrap back to 0 is never used for a write: the pass ends here.
                    if (addr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status flags are registered from the next state so every output is a flop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            w_en_q     <= accept;
            if (accept) begin
                w_addr_q <= addr_q;
                w_data_q <= in_data;
            end
            in_ready_q <= (state_d == LOAD);
            busy_q     <= (state_d == LOAD) || (state_d == FLUSH);
            done_q     <= (state_d == DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            csum_q <= '0;
        end else if (start) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready = in_ready_q;
    assign W_en     = w_en_q;
    assign W_Addr   = w_addr_q;
    assign W_Data   = w_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hlsm_rf_loader.sv
`default_nettype none
// Self-checking bench for hlsm_rf_loader: scoreboard of expected register file
// writes, pushed on each driven accept and popped on each observed W_en.
module tb_hlsm_rf_loader;

    logic       Clk = 1'b0;
    logic       Rst, go, in_valid;
    logic [7:0] in_data;
    logic       in_ready, W_en, busy, done;
    logic [7:0] W_Addr, W_Data, checksum;
    logic [8:0] count;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    hlsm_rf_loader #(.DATA_W(8), .ADDR_W(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .go       (go),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .W_en     (W_en),
        .W_Addr   (W_Addr),
        .W_Data   (W_Data),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .checksum (checksum)
    );

    always #5 Clk = ~Clk;

    task automatic test_reset();
        Rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge Clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (W_en !== 1'b0) begin failures++; $display("FAIL reset_W_en got=%b exp=0", W_en); end
        checks++; if (W_Addr !== 8'h00 || W_Data !== 8'h00) begin failures++; $display("FAIL reset_W_port got=%h/%h exp=00/00", W_Addr, W_Data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", busy, done); end
        checks++; if (count !== 9'd0 || checksum !== 8'h00) begin failures++; $display("FAIL reset_count_csum got=%0d/%h exp=0/00", count, checksum); end
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_go got=%b/%b exp=0/0", in_ready, busy); end
    endtask

    task automatic test_full_pass();
        int accepts = 0;
        wr_t e;
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1 || count !== 9'd0) begin failures++; $display("FAIL full_entry got=%b/%b/%0d exp=1/1/0", in_ready, busy, count); end
        while (accepts < 256) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready acc=%0d got=%b exp=1", accepts, in_ready); end
            in_valid = 1'b1; in_data = accepts[7:0];
            sbq.push_back('{a: accepts[7:0], d: accepts[7:0]});
            accepts++;
            @(negedge Clk);
            checks++;
            if (W_en !== 1'b1) begin
                failures++; $display("FAIL full_wen acc=%0d got=%b exp=1", accepts, W_en);
            end else begin
                e = sbq.pop_front();
                if (W_Addr !== e.a || W_Data !== e.d) begin failures++; $display("FAIL full_write got=%h/%h exp=%h/%h", W_Addr, W_Data, e.a, e.d); end
            end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || count !== 9'd256) begin failures++; $display("FAIL full_flush got=%b/%b/%b/%0d exp=0/1/0/256", in_ready, busy, done, count); end
        @(negedge Clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || W_en !== 1'b0 || count !== 9'd256) begin failures++; $display("FAIL full_done got=%b/%b/%b/%0d exp=1/0/0/256", done, busy, W_en, count); end
        @(negedge Clk);
        checks++; if (done !== 1'b0 || W_Addr !== 8'hFF || W_Data !== 8'hFF) begin failures++; $display("FAIL full_idle_hold got=%b/%h/%h exp=0/ff/ff", done, W_Addr, W_Data); end
        checks++; if (checksum !== (CK_EN ? 8'h80 : 8'h00)) begin failures++; $display("FAIL full_csum got=%h exp=%h", checksum, CK_EN ? 8'h80 : 8'h00); end
        checks++; if (sbq.size() != 0) begin failures++; $display("FAIL full_sb_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_toggle();
        int  accepts = 0, cyc = 0, load_cycles = 0;
        bit  pend;
        logic [7:0] sum = 8'h00;
        wr_t e;
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        while (accepts < 256 && cyc < 2000) begin
            if (in_ready === 1'b1) load_cycles++;
            in_valid = (cyc % 2 == 0);
            in_data  = 8'($urandom);
            if (in_valid) begin
                sbq.push_back('{a: accepts[7:0], d: in_data});
                sum = sum + in_data;
                accepts++;
            end
            pend = in_valid;
            @(negedge Clk);
            cyc++;
            checks++;
            if (W_en !== pend) begin
                failures++; $display("FAIL toggle_wen cyc=%0d got=%b exp=%b", cyc, W_en, pend);
            end else if (pend) begin
                e = sbq.pop_front();
                if (W_Addr !== e.a || W_Data !== e.d) begin failures++; $display("FAIL toggle_write got=%h/%h exp=%h/%h", W_Addr, W_Data, e.a, e.d); end
            end
        end
        in_valid = 1'b0;
        checks++; if (load_cycles != 511) begin failures++; $display("FAIL toggle_load_cycles got=%0d exp=511", load_cycles); end
        @(negedge Clk);
        checks++; if (done !== 1'b1 || count !== 9'd256) begin failures++; $display("FAIL toggle_done got=%b/%0d exp=1/256", done, count); end
        checks++; if (checksum !== (CK_EN ? sum : 8'h00)) begin failures++; $display("FAIL toggle_csum got=%h exp=%h", checksum, CK_EN ? sum : 8'h00); end
        @(negedge Clk);
    endtask

    task automatic test_go_ignored();
        int  accepts = 0;
        int  passes_done = 0;
        wr_t e;
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        while (accepts < 256) begin
            in_valid = 1'b1; in_data = ~accepts[7:0];
            go = (accepts == 50);
            sbq.push_back('{a: accepts[7:0], d: ~accepts[7:0]});
            accepts++;
            @(negedge Clk);
            if (done === 1'b1) passes_done++;
            if (W_en === 1'b1) begin
                e = sbq.pop_front();
                checks++; if (W_Addr !== e.a || W_Data !== e.d) begin failures++; $display("FAIL goign_write got=%h/%h exp=%h/%h", W_Addr, W_Data, e.a, e.d); end
            end
        end
        go = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 9'd256 || in_ready !== 1'b0 || sbq.size() != 0) begin failures++; $display("FAIL goign_flush got=%0d/%b/%0d exp=256/0/0", count, in_ready, sbq.size()); end
        @(negedge Clk);
        checks++; if (done !== 1'b1 || passes_done != 0) begin failures++; $display("FAIL goign_done got=%b/%0d exp=1/0", done, passes_done); end
        go = 1'b1;
        in_valid = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL goign_done_go got=%b/%b/%b exp=0/0/0", in_ready, busy, done); end
        @(negedge Clk);
        checks++; if (in_ready !== 1'b0 || W_en !== 1'b0) begin failures++; $display("FAIL goign_idle got=%b/%b exp=0/0", in_ready, W_en); end
        in_valid = 1'b0;
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        checks++; if (in_ready !== 1'b1 || count !== 9'd0) begin failures++; $display("FAIL goign_restart got=%b/%0d exp=1/0", in_ready, count); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
            @(negedge Clk);
            checks++; if (W_en !== 1'b1 || W_Addr !== 8'(i) || W_Data !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL goign_fresh got=%b/%h/%h exp=1/%h/%h", W_en, W_Addr, W_Data, 8'(i), 8'hA0 + 8'(i)); end
        end
        in_valid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset_midpass();
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'h55;
            @(negedge Clk);
        end
        checks++; if (count !== 9'd100 || W_Addr !== 8'd99) begin failures++; $display("FAIL mid_pre got=%0d/%h exp=100/63", count, W_Addr); end
        Rst = 1'b1; go = 1'b1;
        @(negedge Clk);
        checks++; if (in_ready !== 1'b0 || W_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl got=%b/%b/%b/%b exp=0/0/0/0", in_ready, W_en, busy, done); end
        checks++; if (W_Addr !== 8'h00 || W_Data !== 8'h00 || count !== 9'd0 || checksum !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h/%h/%0d/%h exp=00/00/0/00", W_Addr, W_Data, count, checksum); end
        Rst = 1'b0; go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++; if (W_en !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%b/%b exp=0/0", W_en, in_ready); end
        end
        in_valid = 1'b0;
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge Clk);
        in_valid = 1'b0;
        checks++; if (W_en !== 1'b1 || W_Addr !== 8'h00 || W_Data !== 8'h3C || count !== 9'd1) begin failures++; $display("FAIL mid_restart got=%b/%h/%h/%0d exp=1/00/3c/1", W_en, W_Addr, W_Data, count); end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_checksum();
        go = 1'b1;
        @(negedge Clk);
        go = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            in_valid = 1'b1; in_data = 8'h01;
            @(negedge Clk);
            if (i == 128) begin
                checks++; if (checksum !== (CK_EN ? 8'h80 : 8'h00)) begin failures++; $display("FAIL csum_128 got=%h exp=%h", checksum, CK_EN ? 8'h80 : 8'h00); end
            end
        end
        in_valid = 1'b0;
        @(negedge Clk);
        checks++; if (done !== 1'b1 || checksum !== 8'h00) begin failures++; $display("FAIL csum_256 got=%b/%h exp=1/00", done, checksum); end
        go = 1'b0;
        @(negedge Clk);
        checks++; if (checksum !== 8'h00 || count !== 9'd256) begin failures++; $display("FAIL csum_hold got=%h/%0d exp=00/256", checksum, count); end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_toggle();
        test_go_ignored();
        test_reset_midpass();
        test_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
